bcd_counter_n: RTL and testbench

- Parametrised multi-digit synchronous BCD counter. Generalises the single-digit 0–9 up-counter.
- Adds:
  - DIGITS-wide cascade
  - up/down counting
  - count enable
  - parallel load with digit validation
  - terminal-count output for chaining
  - registered wrap pulse
- Used for decimal event/time counting feeding display and timer logic.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_digit.sv | 63 ++++++
 rtl/bcd_counter_n.sv | 113 +++++++++++
 tb/tb_bcd_counter_n.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Purpose : shared BCD digit constants and helpers for the multi-digit counter.
// Latency : n/a (types, constants and pure functions only).
// Backpr. : n/a.
//
// Contents:
//   BCD_W     - width of one BCD digit
//   BCD_MAX   - largest legal digit value (9)
//   BCD_MIN   - smallest legal digit value (0)
//   bcd_valid - true when a 4-bit nibble is a legal BCD digit
package bcd_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic bcd_valid(input bcd_digit_t digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit.sv
// Purpose : one decade of the BCD counter: load, up/down step, carry/borrow out.
// Latency : 1 cycle from en/carry_in/load sample to digit update; carry_out is combinational.
// Backpr. : none; the digit steps on every edge where en and carry_in are both high.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset, clears the digit
//   en        - step qualifier shared by all digits of the cascade
//   up_dn     - 1 = increment, 0 = decrement
//   carry_in  - carry (up) or borrow (down) arriving from the next-lower digit
//   load      - parallel load strobe, overrides stepping
//   load_dig  - value to load; an illegal nibble (10..15) is loaded as 0
//   digit     - current digit value, always 0..9
//   carry_out - carry/borrow to the next-higher digit
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             carry_in,
  input  logic             load,
  input  logic [BCD_W-1:0] load_dig,
  output logic [BCD_W-1:0] digit,
  output logic             carry_out
);

  logic [BCD_W-1:0] dig_q;
  logic [BCD_W-1:0] dig_d;
  logic             at_edge;
  logic             step;

  // A digit sits at the edge of its range when the next step in the current
  // direction would roll it over (9 going up, 0 going down).
  assign at_edge   = up_dn ? (dig_q == BCD_MAX) : (dig_q == BCD_MIN);
  assign step      = en & carry_in;
  assign carry_out = carry_in & at_edge;

  always_comb begin
    dig_d = dig_q;
    if (load) begin
      dig_d = bcd_valid(load_dig) ? load_dig : BCD_MIN;
    end else if (step) begin
      if (up_dn) begin
        dig_d = at_edge ? BCD_MIN : (dig_q + 4'd1);
      end else begin
        dig_d = at_edge ? BCD_MAX : (dig_q - 4'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dig_q <= BCD_MIN;
    end else begin
      dig_q <= dig_d;
    end
  end

  assign digit = dig_q;

endmodule : bcd_digit

// File: rtl/bcd_counter_n.sv
// Purpose : DIGITS-wide synchronous BCD up/down counter with load, terminal count and wrap pulse.
// Latency : 1 cycle from en/load sample to q; tc is combinational; wrap/load_err are registered.
// Backpr. : none; counts one step on every edge where en is high and neither rst nor load is.
//
// Build option: define BCD_SAT_EN to saturate at all-9s (up) / all-0s (down)
// instead of wrapping modulo 10^DIGITS; wrap is then held at 0.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset; clears q, wrap and load_err
//   en       - count enable, one step per cycle while high
//   up_dn    - 1 = count up, 0 = count down
//   load     - parallel load strobe (priority over en)
//   load_val - BCD value to load, digit 0 in bits [3:0]
//   q        - current BCD count
//   tc       - terminal count: en and all digits at 9 (up) or 0 (down)
//   wrap     - one-cycle pulse coinciding with the wrapped value on q
//   load_err - one-cycle pulse after a load that contained an illegal digit
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] q,
  output logic                    tc,
  output logic                    wrap,
  output logic                    load_err
);

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_counter_n: DIGITS must be in 1..8");
  end

  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] dig_max;
  logic [DIGITS-1:0] dig_min;
  logic [DIGITS-1:0] dig_bad;
  logic              all_max;
  logic              all_min;
  logic              step_en;

  logic              wrap_q;
  logic              wrap_d;
  logic              load_err_q;
  logic              load_err_d;

  // Per-digit range decode for the terminal-count detector and load checks.
  for (genvar i = 0; i < DIGITS; i++) begin : g_decode
    assign dig_max[i] = (q[BCD_W*i +: BCD_W] == BCD_MAX);
    assign dig_min[i] = (q[BCD_W*i +: BCD_W] == BCD_MIN);
    assign dig_bad[i] = !bcd_valid(load_val[BCD_W*i +: BCD_W]);
  end

  assign all_max = &dig_max;
  assign all_min = &dig_min;
  assign tc      = en & (up_dn ? all_max : all_min);

`ifdef BCD_SAT_EN
  // At the terminal count the step is suppressed, so q holds instead of
  // rolling over; tc itself is left visible for cascading.
  assign step_en = en & ~tc;
`else
  assign step_en = en;
`endif

  // Carry chain: digit 0 is always offered a step when counting is enabled;
  // each higher digit steps only when every lower digit rolled over.
  assign carry[0] = step_en;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .rst       (rst),
      .en        (step_en),
      .up_dn     (up_dn),
      .carry_in  (carry[i]),
      .load      (load),
      .load_dig  (load_val[BCD_W*i +: BCD_W]),
      .digit     (q[BCD_W*i +: BCD_W]),
      .carry_out (carry[i+1])
    );
  end

`ifdef BCD_SAT_EN
  assign wrap_d = 1'b0;
`else
  // A carry out of the top digit means the whole counter rolled over this
  // edge; load takes priority and cancels the step.
  assign wrap_d = carry[DIGITS] & ~load;
`endif

  assign load_err_d = load & (|dig_bad);

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule : bcd_counter_n

// File: tb/tb_bcd_counter_n.sv
// Purpose : self-checking bench for bcd_counter_n using an integer reference model and a scoreboard.
// Latency : expectations are pushed at drive time and popped one edge later.
// Backpr. : n/a.
module tb_bcd_counter_n;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         rst;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         tc;
  logic         wrap;
  logic         load_err;

  bcd_counter_n #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic         wrap;
    logic         err;
  } exp_t;

  exp_t exp_q[$];

  int checks;
  int errors;
  int mv;        // reference count as a plain decimal integer
  int modv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [W-1:0] b, output logic bad);
    int v;
    int p;
    v   = 0;
    p   = 1;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] > 4'd9) bad = 1'b1;
      else                    v   = v + int'(b[4*i +: 4]) * p;
      p = p * 10;
    end
    return v;
  endfunction

  // Drive one cycle, check tc before the edge, check the registered
  // outputs one edge later through the scoreboard.
  task automatic cyc(input logic r, input logic l, input logic e, input logic u,
                     input logic [W-1:0] lv);
    exp_t x;
    logic bad;
    logic tc_exp;
    @(negedge clk);
    rst = r; load = l; en = e; up_dn = u; load_val = lv;
    #1;
    tc_exp = e & (u ? (mv == modv - 1) : (mv == 0));
    chk("tc", {31'd0, tc}, {31'd0, tc_exp});
    x.wrap = 1'b0;
    x.err  = 1'b0;
    if (r) begin
      mv = 0;
    end else if (l) begin
      mv    = from_bcd(lv, bad);
      x.err = bad;
    end else if (e) begin
      if (u) begin
        if (mv == modv - 1) begin
`ifdef BCD_SAT_EN
          mv = mv;
`else
          mv = 0; x.wrap = 1'b1;
`endif
        end else mv = mv + 1;
      end else begin
        if (mv == 0) begin
`ifdef BCD_SAT_EN
          mv = mv;
`else
          mv = modv - 1; x.wrap = 1'b1;
`endif
        end else mv = mv - 1;
      end
    end
    x.q = to_bcd(mv);
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    chk("q",        {16'd0, q},       {16'd0, x.q});
    chk("wrap",     {31'd0, wrap},    {31'd0, x.wrap});
    chk("load_err", {31'd0, load_err},{31'd0, x.err});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    modv   = 10 ** DIGITS;
    mv     = 0;
    rst = 1'b1; load = 1'b0; en = 1'b0; up_dn = 1'b1; load_val = '0;
    @(posedge clk);
    // second reset cycle checked through the scoreboard
    cyc(1, 0, 0, 1, '0);

    // count up, first step then digit carry at 10
    cyc(0, 0, 1, 1, '0);
    chk("first_up", {16'd0, q}, 32'h0001);
    repeat (9) cyc(0, 0, 1, 1, '0);
    chk("carry10", {16'd0, q}, 32'h0010);

`ifndef BCD_SAT_EN
    // up wrap
    cyc(0, 1, 0, 1, 16'h9998);
    cyc(0, 0, 1, 1, '0);
    chk("at9999", {16'd0, q}, 32'h9999);
    cyc(0, 0, 1, 1, '0);
    chk("wrap_up", {16'd0, q, 15'd0, wrap}, {16'h0000, 15'd0, 1'b1});
    cyc(0, 0, 1, 1, '0);
    chk("wrap_once", {31'd0, wrap}, 32'd0);

    // down borrow and down wrap
    cyc(0, 1, 0, 0, 16'h1000);
    cyc(0, 0, 1, 0, '0);
    chk("borrow", {16'd0, q}, 32'h0999);
    cyc(0, 1, 0, 0, 16'h0000);
    cyc(0, 0, 1, 0, '0);
    chk("wrap_dn", {16'd0, q}, 32'h9999);
`endif

    // invalid and valid loads
    cyc(0, 1, 0, 1, 16'h12A5);
    chk("bad_load", {16'd0, q, 15'd0, load_err}, {16'h1205, 15'd0, 1'b1});
    cyc(0, 1, 0, 1, 16'h4321);
    chk("good_load", {31'd0, load_err}, 32'd0);
    cyc(0, 1, 0, 1, 16'hFFFF);

    // priorities
    cyc(0, 1, 1, 1, 16'h0500);
    chk("load_over_en", {16'd0, q}, 32'h0500);
    cyc(1, 1, 1, 1, 16'h0700);
    chk("rst_over_load", {16'd0, q}, 32'h0000);
    cyc(0, 1, 0, 1, 16'h0042);
    repeat (20) cyc(0, 0, 0, 0, '0);
    chk("hold", {16'd0, q}, 32'h0042);

    // mid-count reset, then resume from 0
    repeat (3) cyc(0, 0, 1, 1, '0);
    cyc(1, 0, 1, 1, '0);
    cyc(0, 0, 1, 1, '0);
    chk("resume", {16'd0, q}, 32'h0001);

`ifdef BCD_SAT_EN
    cyc(0, 1, 0, 1, 16'h9999);
    repeat (5) cyc(0, 0, 1, 1, '0);
    chk("sat_hi", {16'd0, q}, 32'h9999);
    cyc(0, 0, 1, 0, '0);
    chk("sat_dn", {16'd0, q}, 32'h9998);
    cyc(0, 1, 0, 0, 16'h0000);
    repeat (3) cyc(0, 0, 1, 0, '0);
    chk("sat_lo", {16'd0, q}, 32'h0000);
`endif

    // random traffic, biased to hit loads near the range ends
    for (int n = 0; n < 400; n++) begin
      logic [W-1:0] lv;
      int           sel;
      sel = int'($urandom_range(0, 3));
      lv  = (sel == 0) ? 16'h9999 : (sel == 1) ? 16'h0000 : W'($urandom);
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 3) != 0), 1'($urandom), lv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bcd_counter_n
